// File: rtl/stack_pop_reader.sv
// Pop-side drain engine for a pushdown stack: issues single-cycle pop strobes
// and streams each popped word out on a valid/ready interface.
module stack_pop_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Abort,
  input  logic             StkEmpty,
  input  logic [WIDTH-1:0] StkO,
  output logic             StkEnable,
  output logic             StkPushPop,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Drained
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] drained_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             stop_issue;
  logic             pop_now;

  // Stop before popping when the stack ran dry, the requested count is reached,
  // or an unbounded drain would otherwise overflow the Drained counter.
  assign stop_issue = StkEmpty
                    || ((target_reg != '0) && (drained_reg == target_reg))
                    || ((target_reg == '0) && (drained_reg == CNT_MAX));

  // The strobe depends on StkEmpty in the same cycle, so it cannot be registered.
  assign pop_now    = (state_reg == ISSUE) && !Abort && !stop_issue;

  assign StkEnable  = pop_now;
  assign StkPushPop = pop_now;
  assign OutData    = data_reg;
  assign OutValid   = valid_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign Drained    = drained_reg;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      target_reg  <= '0;
      drained_reg <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (Abort) begin
        // Abort beats every transition; any in-flight word is dropped uncounted.
        state_reg <= IDLE;
        valid_reg <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (Start) begin
              target_reg  <= Count;
              drained_reg <= '0;
              busy_reg    <= 1'b1;
              state_reg   <= ISSUE;
            end
          end
          ISSUE: begin
            if (stop_issue) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= FIN;
            end else begin
              state_reg <= WAIT;
            end
          end
          WAIT: begin
            data_reg  <= StkO;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
          HOLD: begin
            if (OutReady) begin
              valid_reg   <= 1'b0;
              drained_reg <= drained_reg + 1'b1;
              state_reg   <= ISSUE;
            end
          end
          FIN: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_pop_reader.sv
// Bench for stack_pop_reader: behavioural stack, table-driven drains with a
// word scoreboard, plus hand-written hold, abort, reset and empty sequences.
module tb_stack_pop_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 10;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             Start;
  logic [CNT_W-1:0] Count;
  logic             Abort;
  logic             StkEmpty;
  logic [WIDTH-1:0] StkO;
  logic             StkEnable;
  logic             StkPushPop;
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             OutReady;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Drained;

  always #5 CLK = ~CLK;

  stack_pop_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Count(Count), .Abort(Abort),
    .StkEmpty(StkEmpty), .StkO(StkO), .StkEnable(StkEnable),
    .StkPushPop(StkPushPop), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Done(Done), .Drained(Drained)
  );

  // Behavioural pushdown stack: registered O on pop, combinational Empty.
  logic [WIDTH-1:0] mem [0:1023];
  logic [10:0]      sp = '0;
  logic             push_en = 1'b0;
  logic             clr_en = 1'b0;
  logic [WIDTH-1:0] push_val = '0;
  logic [10:0]      sp_m1;

  assign sp_m1    = sp - 11'd1;
  assign StkEmpty = (sp == 11'd0);

  always @(posedge CLK) begin
    if (clr_en) begin
      sp <= '0;
    end else if (push_en) begin
      mem[sp[9:0]] <= push_val;
      sp <= sp + 11'd1;
    end else if (StkEnable && StkPushPop && (sp != 11'd0)) begin
      StkO <= mem[sp_m1[9:0]];
      sp   <= sp_m1;
    end
  end

  int               tests_run = 0;
  int               fails = 0;
  int               pop_cnt = 0;
  bit               done_flag = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge CLK);
    if (Reset && OutValid && OutReady && !Abort) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL sb_extra: unexpected word 0x%0h, none expected", OutData);
      end else begin
        check("sb_word", {24'd0, OutData}, {24'd0, exp_q.pop_front()});
      end
    end
    if (Done) done_flag = 1'b1;
    if (StkEnable) pop_cnt++;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_stack();
    clr_en = 1'b1;
    cyc();
    clr_en = 1'b0;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push_en  = 1'b1;
      push_val = WIDTH'(base + i);
      cyc();
    end
    push_en = 1'b0;
  endtask

  // Expected words come from the bench's own stack contents, top first.
  task automatic start_drain(input int cnt);
    int n;
    int depth;
    depth = int'(sp);
    n = (cnt == 0) ? depth : ((cnt < depth) ? cnt : depth);
    if (n > 1023) n = 1023;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[depth - 1 - i]);
    Start = 1'b1;
    Count = CNT_W'(cnt);
    cyc();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    done_flag = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      cyc();
      if (done_flag) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (OutValid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  typedef struct {
    bit clr;
    int n;
    int base;
    int cnt;
    int exp_dr;
    int exp_left;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit               ok;
    bit               stable;
    int               p0;
    logic [WIDTH-1:0] held;

    vecs[0] = '{1'b1, 5,    'h10, 0, 5,    0};
    vecs[1] = '{1'b1, 8,    'h20, 3, 3,    5};
    vecs[2] = '{1'b0, 2,    'h40, 0, 7,    0};
    vecs[3] = '{1'b1, 0,    'h00, 0, 0,    0};
    vecs[4] = '{1'b1, 2,    'h30, 5, 2,    0};
    vecs[5] = '{1'b1, 1023, 'h00, 0, 1023, 0};

    Reset = 1'b0; Start = 1'b0; Count = '0; Abort = 1'b0; OutReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy",    {31'd0, Busy},      0);
    check("rst_valid",   {31'd0, OutValid},  0);
    check("rst_done",    {31'd0, Done},      0);
    check("rst_enable",  {31'd0, StkEnable}, 0);
    check("rst_drained", {22'd0, Drained},   0);
    check("rst_data",    {24'd0, OutData},   0);
    Reset = 1'b1;
    cyc();

    // Table-driven drains with OutReady tied high.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr) clear_stack();
      push_words(vecs[v].n, vecs[v].base);
      OutReady = 1'b1;
      p0 = pop_cnt;
      start_drain(vecs[v].cnt);
      wait_done(4000, ok);
      check("tbl_done_seen", {31'd0, ok}, 1);
      check("tbl_drained", {22'd0, Drained}, vecs[v].exp_dr);
      check("tbl_pops", pop_cnt - p0, vecs[v].exp_dr);
      check("tbl_stack_left", {21'd0, sp}, vecs[v].exp_left);
      check("tbl_sb_empty", exp_q.size(), 0);
      check("tbl_busy_idle", {31'd0, Busy}, 0);
    end

    // Empty stack: Done two cycles after the Start cycle, no strobe.
    clear_stack();
    p0 = pop_cnt;
    start_drain(0);
    done_flag = 1'b0;
    cyc();
    check("empty_done_early", {31'd0, done_flag}, 0);
    cyc();
    check("empty_done_2cyc", {31'd0, done_flag}, 1);
    check("empty_pops", pop_cnt - p0, 0);
    check("empty_drained", {22'd0, Drained}, 0);

    // Backpressure: word held stable, no second pop while held.
    clear_stack();
    push_words(4, 'h50);
    OutReady = 1'b0;
    p0 = pop_cnt;
    start_drain(0);
    wait_valid(ok);
    check("hold_valid_seen", {31'd0, ok}, 1);
    held = OutData;
    check("hold_top_word", {24'd0, held}, 'h53);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!OutValid || (OutData !== held)) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 1);
    check("hold_single_pop", pop_cnt - p0, 1);
    OutReady = 1'b1;
    wait_done(100, ok);
    check("hold_done_seen", {31'd0, ok}, 1);
    check("hold_drained", {22'd0, Drained}, 4);
    check("hold_sb_empty", exp_q.size(), 0);

    // Abort in HOLD with two words already accepted.
    clear_stack();
    push_words(6, 'h60);
    OutReady = 1'b0;
    start_drain(0);
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      check("abort_pre_valid", {31'd0, ok}, 1);
      OutReady = 1'b1;
      cyc();
      OutReady = 1'b0;
    end
    wait_valid(ok);
    check("abort_third_valid", {31'd0, ok}, 1);
    check("abort_drained_pre", {22'd0, Drained}, 2);
    Abort = 1'b1;
    OutReady = 1'b1;
    done_flag = 1'b0;
    cyc();
    Abort = 1'b0;
    OutReady = 1'b0;
    check("abort_valid", {31'd0, OutValid}, 0);
    check("abort_busy", {31'd0, Busy}, 0);
    check("abort_drained", {22'd0, Drained}, 2);
    cyc();
    check("abort_no_done", {31'd0, done_flag}, 0);
    check("abort_stack_left", {21'd0, sp}, 3);
    exp_q.delete();
    OutReady = 1'b1;
    start_drain(0);
    check("resume_first_exp", {24'd0, exp_q[0]}, 'h62);
    wait_done(100, ok);
    check("resume_done_seen", {31'd0, ok}, 1);
    check("resume_drained", {22'd0, Drained}, 3);
    check("resume_sb_empty", exp_q.size(), 0);

    // Start together with Abort in IDLE is dropped.
    push_words(2, 'h71);
    p0 = pop_cnt;
    Start = 1'b1;
    Abort = 1'b1;
    Count = '0;
    cyc();
    Start = 1'b0;
    Abort = 1'b0;
    check("startabort_busy", {31'd0, Busy}, 0);
    cyc();
    cyc();
    check("startabort_pops", pop_cnt - p0, 0);

    // Asynchronous reset in the middle of a drain.
    OutReady = 1'b0;
    start_drain(0);
    wait_valid(ok);
    check("rstmid_valid_seen", {31'd0, ok}, 1);
    #2 Reset = 1'b0;
    #1;
    check("rstmid_valid",   {31'd0, OutValid},   0);
    check("rstmid_busy",    {31'd0, Busy},       0);
    check("rstmid_enable",  {31'd0, StkEnable},  0);
    check("rstmid_pushpop", {31'd0, StkPushPop}, 0);
    check("rstmid_data",    {24'd0, OutData},    0);
    check("rstmid_drained", {22'd0, Drained},    0);
    exp_q.delete();
    cyc();
    Reset = 1'b1;
    cyc();
    check("rstmid_idle", {31'd0, Busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
